// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared types and default geometry for the systolic array path
//            (input feeder, skew buffer, array).
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Default lane width, array dimension and address/count widths shared by
  // the feeder, the skew buffer and the array itself.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LENGTH     = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_CNT_WIDTH  = 16;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_input_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_input_feeder
// Purpose  : Streams num_vec consecutive vectors from a single-port SRAM onto
//            dout (one per cycle), then drives LENGTH zero cycles so the
//            deepest skew row drains, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LENGTH     = DEF_LENGTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [CNT_WIDTH-1:0]         num_vec,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH*LENGTH-1:0] mem_rdata,
  output logic [DATA_WIDTH*LENGTH-1:0] dout,
  output logic                         dout_valid
);

  localparam int                 FLUSH_W    = count_width(LENGTH);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(LENGTH);

  feeder_state_t        state;
  logic [CNT_WIDTH-1:0] num_reg;    // vectors requested by the active command
  logic [CNT_WIDTH-1:0] rd_cnt;     // reads issued so far
  logic [FLUSH_W-1:0]   flush_cnt;  // zero cycles already driven (1..LENGTH)
  logic                 rd_valid;   // a read was issued last cycle, data arrives now
  logic                 accept;

  // A command is taken whenever the block is not busy; this includes the
  // cycle where done is high, so commands can be issued back to back.
  assign accept = start && !busy;

  // Sequencer: command capture, read issue, drain/flush timing and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      num_reg   <= '0;
      rd_cnt    <= '0;
      flush_cnt <= '0;
    end else if (accept) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      num_reg   <= num_vec;
      flush_cnt <= '0;
      if (num_vec != '0) begin
        // First read goes out on the accepting edge itself.
        state    <= ST_READ;
        mem_en   <= 1'b1;
        mem_addr <= base_addr;
        rd_cnt   <= CNT_WIDTH'(1);
      end else begin
        // Empty command: nothing to read and nothing to flush.
        state  <= ST_DONE;
        mem_en <= 1'b0;
        rd_cnt <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
        end
        ST_READ: begin
          if (rd_cnt == num_reg) begin
            mem_en <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            // Address wraps naturally at the top of the SRAM.
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            rd_cnt   <= rd_cnt + CNT_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          // Flush cycles start once the final read's data has been
          // registered onto dout (no read remains in flight).
          if (!rd_valid) begin
            if (flush_cnt == FLUSH_LAST) begin
              flush_cnt <= '0;
              state     <= ST_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (!done) begin
            // Entered from an empty command: pulse done one cycle later.
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return pipeline: register returning data onto dout, zero otherwise,
  // since the downstream skew buffer shifts every cycle without an enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      rd_valid   <= mem_en;
      dout_valid <= rd_valid;
      dout       <= rd_valid ? mem_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_input_feeder
// Purpose  : Self-checking bench for systolic_input_feeder. Expected behaviour
//            per cycle is derived from the command (base, count) and the
//            cycle offset from the accepting edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_input_feeder;
  import systolic_pkg::*;

  localparam int DW    = 8;
  localparam int LEN   = 16;
  localparam int AW    = 10;
  localparam int CW    = 16;
  localparam int VW    = DW * LEN;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_vec = '0;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_rdata = '0;
  logic [VW-1:0] dout;
  logic          dout_valid;

  logic [VW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  systolic_input_feeder #(
    .DATA_WIDTH(DW),
    .LENGTH    (LEN),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: read data valid one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic fill_pattern();
    logic [7:0] b;
    for (int a = 0; a < DEPTH; a++) begin
      b = 8'(a);
      mem[a] = {LEN{b}};
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++)
      for (int l = 0; l < LEN; l++)
        mem[a][DW*l +: DW] = 8'($urandom);
  endtask

  // Issue (or continue) one command and check every cycle from the accepting
  // edge through completion. Expected outputs at offset c after edge E_c:
  //   mem_en for c < n at address base+c (mod 2^AW)
  //   dout = word(base+c-2) for 2 <= c <= n+1, zero otherwise
  //   busy for c < n+2+LEN, done at c == n+2+LEN (empty command: busy at c=0,
  //   done at c=1)
  task automatic run_cmd(input string tag, input int base, input int n,
                         input bit prestarted, input bit chain,
                         input int nbase, input int nn, input bit busy_poke);
    int            last_c;
    int            stop_c;
    bit            e_en, e_dv, e_busy, e_done;
    logic [VW-1:0] e_dout;
    logic [AW-1:0] e_addr;
    last_c = (n == 0) ? 1 : n + 2 + LEN;
    stop_c = chain ? last_c : last_c + 1;
    if (!prestarted) begin
      @(negedge clk);
      start     = 1'b1;
      base_addr = AW'(base);
      num_vec   = CW'(n);
    end
    for (int c = 0; c <= stop_c; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy_poke && c == 1) begin
        start     = 1'b1;
        base_addr = AW'(base + 300);
        num_vec   = CW'(n + 5);
      end
      e_en   = (c < n);
      e_dv   = (n > 0) && (c >= 2) && (c <= n + 1);
      e_busy = (n == 0) ? (c == 0) : (c < n + 2 + LEN);
      e_done = (c == last_c);
      e_addr = AW'((base + c) % DEPTH);
      e_dout = e_dv ? mem[(base + c - 2) % DEPTH] : '0;
      checks++;
      if ({busy, done, mem_en, dout_valid} !== {e_busy, e_done, e_en, e_dv}) begin
        failures++;
        $display("FAIL %s ctrl c=%0d busy/done/en/valid got=%b exp=%b", tag, c,
                 {busy, done, mem_en, dout_valid}, {e_busy, e_done, e_en, e_dv});
      end
      if (e_en) begin
        checks++;
        if (mem_addr !== e_addr) begin
          failures++;
          $display("FAIL %s mem_addr c=%0d got=%0d exp=%0d", tag, c, mem_addr, e_addr);
        end
      end
      checks++;
      if (dout !== e_dout) begin
        failures++;
        $display("FAIL %s dout c=%0d got=%h exp=%h", tag, c, dout, e_dout);
      end
      if (chain && c == last_c) begin
        start     = 1'b1;
        base_addr = AW'(nbase);
        num_vec   = CW'(nn);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, done, mem_en, dout_valid} !== 4'b0 || mem_addr !== '0 || dout !== '0) begin
      failures++;
      $display("FAIL %s zero busy/done/en/valid=%b addr=%0d dout=%h exp all zero",
               tag, {busy, done, mem_en, dout_valid}, mem_addr, dout);
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      base_addr = AW'($urandom);
      num_vec   = CW'($urandom);
      #1 check_all_zero("reset");
    end
    @(negedge clk);
    start = 1'b0;
    rstn  = 1'b1;
  endtask

  task automatic test_basic();
    fill_pattern();
    run_cmd("basic", 5, 3, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    fill_random();
    run_cmd("wrap", 1022, 4, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_zero_count();
    run_cmd("zero", 77, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_cmd("busy_start", 40, 5, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_first", 100, 3, 1'b0, 1'b1, 1020, 6, 1'b0);
    run_cmd("b2b_second", 1020, 6, 1'b1, 1'b1, 9, 0, 1'b0);
    run_cmd("b2b_zero", 9, 0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(200);
    num_vec   = CW'(8);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre en/busy got=%b%b exp=11", mem_en, busy);
    end
    rstn = 1'b0;
    #1 check_all_zero("rst_mid_now");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all_zero("rst_mid_hold");
    end
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all_zero("rst_mid_idle");
    end
    run_cmd("post_rst", 300, 2, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int b, n;
    for (int i = 0; i < 5; i++) begin
      fill_random();
      b = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 24));
      run_cmd("random", b, n, 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
